core_inst_sequencer: RTL and testbench

- On-chip instruction generator for `core`. It produces the 34-bit `inst` word that the host currently drives cycle by cycle.
- After one `start` pulse it runs the full convolution schedule for one input/output tile. The schedule loops over `len_kij` kernel positions; each pass is weight SRAM→L0→PE load, activation SRAM→L0, execute, then OFIFO drain with accumulate.
- Sits between the system controller and `core.inst`, and consumes `core.ofifo_valid`.

---
 rtl/core_inst_sequencer.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_core_inst_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_inst_sequencer.sv
// ---------------------------------------------------------------------------
// core_inst_sequencer
//   Generates the 34-bit core instruction word for one tile. A single start
//   pulse runs len_kij kernel positions. Each position does a weight read into
//   L0, a PE weight load, a settle gap, an activation read into L0, execute,
//   and an OFIFO drain that accumulates into psum memory.
//
// Ports
//   clk          in   clock
//   reset        in   asynchronous, active-high reset
//   start        in   begin schedule (sampled only while idle)
//   ofifo_valid  in   core OFIFO holds a readable vector
//   inst[33:0]   out  registered core instruction word
//   busy         out  schedule in progress
//   done         out  one-cycle pulse when the schedule ends
//   kij[3:0]     out  current kernel position (debug)
// ---------------------------------------------------------------------------
module core_inst_sequencer #(
  parameter int          bw       = 4,
  parameter int          row      = 8,
  parameter int          col      = 8,
  parameter int          len_kij  = 9,
  parameter int          len_nij  = 36,
  parameter int          len_onij = 16,
  parameter int          gap_cyc  = 10,
  parameter logic [10:0] w_base   = 11'h400,
  parameter logic [10:0] a_base   = 11'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij
);

  // Instruction field positions
  localparam int B_ACC      = 33;
  localparam int B_CEN_X    = 19;
  localparam int A_X_HI     = 17;
  localparam int A_X_LO     = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  // Both memories deselected with write disabled; all strobes low.
  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

  localparam int EXEC_LEN = row + col + len_nij;

  // bw only matters to the core datapath; it is folded in as zero here so the
  // parameter remains part of the interface without affecting sizing.
  localparam int PH_MAX = row + col + len_nij + len_nij + col + gap_cyc + 4 + 0 * bw;
  localparam int CNT_W  = $clog2(PH_MAX + 1);
  localparam int RD_W   = $clog2(len_onij + 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_W_RD   = 4'd1,
    S_W_LOAD = 4'd2,
    S_GAP    = 4'd3,
    S_A_RD   = 4'd4,
    S_EXEC   = 4'd5,
    S_DRAIN  = 4'd6,
    S_NEXT   = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [RD_W-1:0]    r_rd_cnt, w_rd_cnt_nxt;
  logic [3:0]         r_kij, w_kij_nxt;
  logic               w_fire;
  logic [33:0]        r_inst, w_inst_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic [10:0]        w_idx;

  assign inst = r_inst;
  assign busy = r_busy;
  assign done = r_done;
  assign kij  = r_kij;

  // State, phase counter, drain read counter and kernel index registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rd_cnt <= '0;
      r_kij    <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rd_cnt <= w_rd_cnt_nxt;
      r_kij    <= w_kij_nxt;
    end
  end

  // Next-state, counter and drain handshake decisions
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + CNT_W'(1);
    w_rd_cnt_nxt = r_rd_cnt;
    w_kij_nxt    = r_kij;
    w_fire       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (start) begin
          w_state_nxt = S_W_RD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_W_RD: begin
        if (r_cnt == CNT_W'(col + 1)) begin
          w_state_nxt = S_W_LOAD;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_W_RD;
        end
      end
      S_W_LOAD: begin
        if (r_cnt == CNT_W'(row + col - 1)) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_W_LOAD;
        end
      end
      S_GAP: begin
        if (r_cnt == CNT_W'(gap_cyc)) begin
          w_state_nxt = S_A_RD;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_GAP;
        end
      end
      S_A_RD: begin
        if (r_cnt == CNT_W'(len_nij + 1)) begin
          w_state_nxt = S_EXEC;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_A_RD;
        end
      end
      S_EXEC: begin
        // The trailing idle EXEC cycle already has rd low, so the first
        // drain read may be issued on the edge that enters DRAIN.
        if (r_cnt == CNT_W'(EXEC_LEN)) begin
          w_state_nxt  = S_DRAIN;
          w_cnt_nxt    = '0;
          w_rd_cnt_nxt = '0;
          w_fire       = ofifo_valid & ~r_inst[B_OFIFO_RD];
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_DRAIN: begin
        w_cnt_nxt = '0;
        if (r_rd_cnt == RD_W'(len_onij)) begin
          // Last read still on the bus: emit one clear cycle before leaving.
          if (r_inst[B_OFIFO_RD]) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_NEXT;
          end
        end else begin
          // Never read on consecutive cycles: valid may lag a read by one.
          w_fire      = ofifo_valid & ~r_inst[B_OFIFO_RD];
          w_state_nxt = S_DRAIN;
        end
      end
      S_NEXT: begin
        w_cnt_nxt = '0;
        if (r_kij == 4'(len_kij - 1)) begin
          w_state_nxt = S_DONE;
          w_kij_nxt   = 4'd0;
        end else begin
          w_state_nxt = S_W_RD;
          w_kij_nxt   = r_kij + 4'd1;
        end
      end
      S_DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_nxt    = '0;
        w_rd_cnt_nxt = '0;
        w_kij_nxt    = 4'd0;
        w_state_nxt  = S_IDLE;
      end
    endcase
    if (w_fire) begin
      w_rd_cnt_nxt = w_rd_cnt_nxt + RD_W'(1);
    end else begin
      w_rd_cnt_nxt = w_rd_cnt_nxt;
    end
  end

  // Instruction word for the state being entered, so inst lines up with state
  always_comb begin
    w_inst_nxt = IDLE_WORD;
    w_idx      = 11'd0;
    w_busy_nxt = 1'b1;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
      end
      S_W_RD: begin
        // Address advances while reading, then holds on the last row.
        if (w_cnt_nxt < CNT_W'(col)) begin
          w_idx               = 11'(w_cnt_nxt);
          w_inst_nxt[B_CEN_X] = 1'b0;
        end else begin
          w_idx = 11'(col - 1);
        end
        w_inst_nxt[A_X_HI:A_X_LO] = w_base + 11'(w_kij_nxt) * 11'(col) + w_idx;
        // SRAM data lands one cycle after its address.
        if ((w_cnt_nxt >= CNT_W'(1)) && (w_cnt_nxt <= CNT_W'(col))) begin
          w_inst_nxt[B_L0_WR] = 1'b1;
        end else begin
          w_inst_nxt[B_L0_WR] = 1'b0;
        end
      end
      S_W_LOAD: begin
        w_inst_nxt[B_LOAD]  = 1'b1;
        w_inst_nxt[B_L0_RD] = 1'b1;
      end
      S_A_RD: begin
        if (w_cnt_nxt < CNT_W'(len_nij)) begin
          w_idx               = 11'(w_cnt_nxt);
          w_inst_nxt[B_CEN_X] = 1'b0;
        end else begin
          w_idx = 11'(len_nij - 1);
        end
        w_inst_nxt[A_X_HI:A_X_LO] = a_base + w_idx;
        if ((w_cnt_nxt >= CNT_W'(1)) && (w_cnt_nxt <= CNT_W'(len_nij))) begin
          w_inst_nxt[B_L0_WR] = 1'b1;
        end else begin
          w_inst_nxt[B_L0_WR] = 1'b0;
        end
      end
      S_EXEC: begin
        if (w_cnt_nxt < CNT_W'(EXEC_LEN)) begin
          w_inst_nxt[B_EXEC]  = 1'b1;
          w_inst_nxt[B_L0_RD] = 1'b1;
        end else begin
          w_inst_nxt[B_EXEC]  = 1'b0;
          w_inst_nxt[B_L0_RD] = 1'b0;
        end
      end
      S_DRAIN: begin
        w_inst_nxt[B_OFIFO_RD] = w_fire;
        w_inst_nxt[B_ACC]      = w_fire;
      end
      S_DONE: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b1;
      end
      default: begin
        w_inst_nxt = IDLE_WORD;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inst <= IDLE_WORD;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_inst <= w_inst_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_core_inst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_core_inst_sequencer
//   Directed bench for core_inst_sequencer at default parameters. Outputs are
//   sampled 1 ns after each rising edge; inputs change at the same instant.
// ---------------------------------------------------------------------------
module tb_core_inst_sequencer;

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
  // Cycles per kernel position with an always-valid OFIFO: 129 fixed + 32 drain.
  localparam int KIJ_CYC = 161;

  logic        clk;
  logic        reset;
  logic        start;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij;

  int n_checks;
  int n_fail;

  logic [33:0] tr[$];
  logic [3:0]  tk[$];

  core_inst_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done),
    .kij         (kij)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int cnt_bit(input int b, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) begin
      if (i < tr.size() && tr[i][b]) c++;
    end
    return c;
  endfunction

  function automatic int cnt_idle(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) begin
      if (i < tr.size() && tr[i] == IDLE_W) c++;
    end
    return c;
  endfunction

  function automatic logic [10:0] addr_at(input int i);
    logic [33:0] w = 34'h0;
    if (i < tr.size()) w = tr[i];
    return w[17:7];
  endfunction

  function automatic logic [33:0] word_at(input int i);
    logic [33:0] w = 34'h0;
    if (i < tr.size()) w = tr[i];
    return w;
  endfunction

  // Start, record every cycle until done, then check the schedule shape.
  task automatic full_run(input string nm);
    int done_idx = -1;
    int n_done = 0;
    int guard = 0;
    int n_prime = 0;
    int b2b = 0;
    int acc_bad = 0;
    logic busy0 = 1'b0;
    logic busy_dn = 1'b1;
    logic [3:0] kij_dn = 4'hF;
    logic [33:0] w;
    tr.delete();
    tk.delete();
    ofifo_valid = 1'b1;
    start = 1'b1;
    while (n_done == 0 && guard < 3000) begin
      step();
      start = 1'b0;
      tr.push_back(inst);
      tk.push_back(kij);
      if (tr.size() == 1) busy0 = busy;
      if (done) begin
        n_done++;
        done_idx = tr.size() - 1;
        busy_dn  = busy;
        kij_dn   = kij;
      end
      guard++;
    end
    repeat (5) begin
      step();
      if (done) n_done++;
    end
    for (int i = 0; i < tr.size(); i++) begin
      w = tr[i];
      if (w[17] && !w[19] && !w[2]) n_prime++;
      if (w[33] !== w[6]) acc_bad++;
      if (i > 0 && w[6] && tr[i-1][6]) b2b++;
    end
    check_eq({nm, "_busy_first"}, busy0, 1);
    // Weight read, kij=0
    check_eq({nm, "_w_prime_addr"}, addr_at(0), 11'h400);
    check_eq({nm, "_w_prime_cen"}, word_at(0) & 34'h8_0004, 34'h0);
    check_eq({nm, "_w_addr1"}, addr_at(1), 11'h401);
    check_eq({nm, "_w_addr7"}, addr_at(7), 11'h407);
    check_eq({nm, "_w_addr_hold"}, addr_at(8), 11'h407);
    check_eq({nm, "_w_l0wr_cnt"}, cnt_bit(2, 0, 9), 8);
    check_eq({nm, "_w_final"}, word_at(9), {1'b0, 2'b11, 11'h0, 2'b11, 11'h407, 7'h0});
    // Weight load, gap
    check_eq({nm, "_load_cnt"}, cnt_bit(0, 10, 25), 16);
    check_eq({nm, "_load_l0rd_cnt"}, cnt_bit(3, 10, 25), 16);
    check_eq({nm, "_gap_idle"}, cnt_idle(26, 36), 11);
    // Activation read
    check_eq({nm, "_a_prime"}, word_at(37), {1'b0, 2'b11, 11'h0, 2'b01, 11'h000, 7'h0});
    check_eq({nm, "_a_l0wr_cnt"}, cnt_bit(2, 37, 74), 36);
    check_eq({nm, "_a_last_addr"}, addr_at(72), 11'h023);
    check_eq({nm, "_a_cen_off"}, word_at(73), {1'b0, 2'b11, 11'h0, 2'b11, 11'h023, 7'h4});
    check_eq({nm, "_a_final"}, word_at(74), {1'b0, 2'b11, 11'h0, 2'b11, 11'h023, 7'h0});
    // Execute
    check_eq({nm, "_exec_cnt"}, cnt_bit(1, 75, 127), 52);
    check_eq({nm, "_exec_tail"}, word_at(127), IDLE_W);
    // Drain
    check_eq({nm, "_drain_rd_cnt"}, cnt_bit(6, 128, 159), 16);
    check_eq({nm, "_drain_first"}, word_at(128), 34'h3_800C_0040);
    check_eq({nm, "_drain_clear"}, word_at(159), IDLE_W);
    check_eq({nm, "_next_idle"}, word_at(160), IDLE_W);
    check_eq({nm, "_rd_b2b"}, b2b, 0);
    check_eq({nm, "_acc_eq_rd"}, acc_bad, 0);
    // Later kernel positions
    check_eq({nm, "_kij1_addr"}, addr_at(KIJ_CYC), 11'h408);
    check_eq({nm, "_kij3_addr"}, addr_at(3 * KIJ_CYC), 11'h418);
    check_eq({nm, "_kij3_val"}, (3 * KIJ_CYC < tk.size()) ? tk[3 * KIJ_CYC] : 4'hF, 3);
    check_eq({nm, "_wrd_phases"}, n_prime, 9);
    // End of schedule
    check_eq({nm, "_done_idx"}, done_idx, 9 * KIJ_CYC);
    check_eq({nm, "_done_once"}, n_done, 1);
    check_eq({nm, "_busy_at_done"}, busy_dn, 0);
    check_eq({nm, "_kij_at_done"}, kij_dn, 0);
    check_eq({nm, "_busy_after"}, busy, 0);
  endtask

  // Hard stop if anything above stops advancing.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rd;
    int guard;
    int stall_rd;
    int b2b;
    int acc_bad;
    logic prev;
    logic stalled;

    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    start       = 1'b0;
    ofifo_valid = 1'b0;

    // Reset values, held with no start
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("rst_inst", inst, IDLE_W);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_kij", kij, 0);
    end

    full_run("run1");

    // Drain stall in kij=0
    ofifo_valid = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n_rd = 0; guard = 0; b2b = 0; acc_bad = 0; prev = 1'b0; stalled = 1'b0; stall_rd = 0;
    while (n_rd < 16 && guard < 2000) begin
      step();
      guard++;
      if (inst[6]) begin
        n_rd++;
        if (prev) b2b++;
      end
      if (inst[33] !== inst[6]) acc_bad++;
      prev = inst[6];
      if (n_rd == 5 && !stalled) begin
        stalled = 1'b1;
        ofifo_valid = 1'b0;
        step();
        repeat (50) begin
          step();
          if (inst[6]) stall_rd++;
        end
        check_eq("stall_no_rd", stall_rd, 0);
        check_eq("stall_inst", inst, IDLE_W);
        check_eq("stall_busy", busy, 1);
        check_eq("stall_kij", kij, 0);
        ofifo_valid = 1'b1;
        prev = 1'b0;
      end
    end
    check_eq("stall_total_rd", n_rd, 16);
    check_eq("stall_b2b", b2b, 0);
    check_eq("stall_acc", acc_bad, 0);
    step();
    check_eq("stall_clear", inst, IDLE_W);
    step();
    check_eq("stall_next", inst, IDLE_W);
    step();
    check_eq("stall_kij1_addr", inst[17:7], 11'h408);
    check_eq("stall_kij1", kij, 1);

    // Start during EXEC is ignored
    guard = 0;
    while (!inst[1] && guard < 500) begin
      step();
      guard++;
    end
    check_eq("exec_reached", inst[1], 1);
    repeat (10) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("start_ign_exec", inst[1], 1);
    check_eq("start_ign_l0wr", inst[2], 0);
    check_eq("start_ign_kij", kij, 1);
    check_eq("start_ign_busy", busy, 1);

    // Asynchronous reset between edges mid-EXEC
    step();
    #3;
    reset = 1'b1;
    #1;
    check_eq("arst_inst", inst, IDLE_W);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_kij", kij, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) step();
    check_eq("post_rst_idle", inst, IDLE_W);

    full_run("run2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
